apb4_multi_slave_master: RTL and testbench
==========================================

Name: apb4_multi_slave_master

Overview:
- Parametrised APB4 master bridge; next generation of the single-slave APB bus interface.
- Converts a simple stimulus-side request (transfer/SWRITE/SADDR/SWDATA/SSTRB/SPROT) into APB4 SETUP/ACCESS phases.
- Decodes the address to one of NUM_SLAVES PSEL lines and muxes the selected slave's response back.
- Adds back-to-back transfers, decode-error reporting and a PREADY timeout watchdog; sits between testbench/CPU-side stimulus and the APB slave fabric (RAM and peripherals).

Parameters:
- ADDR_WIDTH, 32, width of SADDR/PADDR.
- DATA_WIDTH, 32, width of data buses; must be a multiple of 8.
- NUM_SLAVES, 4, number of PSEL outputs (1..2**SEL_BITS).
- SEL_LSB, 12, LSB of the slave-index field in SADDR.
- SEL_BITS, 3, width of the slave-index field.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before forced error; 0 disables.

Ports:
- PCLK  in  1  bus clock, all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- transfer  in  1  request valid.
- SWRITE  in  1  1=write, 0=read.
- SADDR  in  ADDR_WIDTH  request address.
- SWDATA  in  DATA_WIDTH  write data.
- SSTRB  in  DATA_WIDTH/8  write byte strobes.
- SPROT  in  3  protection attributes.
- s_ready  out  1  request accepted this cycle when transfer&&s_ready (combinational).
- s_done  out  1  one-cycle completion pulse.
- s_rdata  out  DATA_WIDTH  read data, valid with s_done.
- s_err  out  1  error flag, valid with s_done.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE, PWRITE  out  1  APB4 control.
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  DATA_WIDTH/8; PPROT  out  3.
- PREADY, PSLVERR  in  NUM_SLAVES  per-slave response.
- PRDATA  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (async, PRESET=1): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, s_done, s_rdata, s_err all 0; timeout counter 0. Assertion mid-transfer drops PSEL/PENABLE immediately; no s_done is produced for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- s_ready = (state==IDLE) || (state==ACCESS && PREADY[idx]) || (state==ACCESS && timeout expiring).
- Accept (transfer&&s_ready at edge): register address, data, control; idx = SADDR[SEL_LSB +: SEL_BITS].
- Valid idx (<NUM_SLAVES): next state SETUP; PSEL[idx]=1, PENABLE=0; PADDR/PWRITE/PWDATA/PPROT driven. PSTRB = SSTRB on write, forced 0 on read.
- Invalid idx: no PSEL asserted; state stays IDLE; next cycle s_done=1, s_err=1, s_rdata=0.
- SETUP -> ACCESS unconditionally after one cycle; PENABLE=1; address/control held stable.
- ACCESS, PREADY[idx]=1 at edge: complete. s_done=1 next cycle with s_err=PSLVERR[idx] and s_rdata=PRDATA[idx] (reads; 0 on writes). If a new request is accepted on the same edge -> SETUP (no idle cycle, PENABLE drops to 0, PSEL moves to new slave); else -> IDLE with all PSEL/PENABLE 0.
- Timeout: counter increments each ACCESS cycle with PREADY[idx]=0. At the edge ending the TIMEOUT_CYCLES-th such cycle, force completion: s_err=1, s_rdata=0, bus released as above. Counter clears on every accept.
- Only PREADY/PSLVERR/PRDATA of the selected slave are observed; other slaves' inputs are ignored.
- Minimum cost: 2 bus cycles per access; throughput 1 access per 2 cycles back-to-back.

Test Plan:
- Write SADDR=0x0000_1004, SWDATA=0xDEADBEEF, SSTRB=0xF, slave 1 PREADY=1 -> PSEL=4'b0010 SETUP then ACCESS, PSTRB=0xF, s_done on cycle 3 with s_err=0.
- Read SADDR=0x0000_3010, slave 3 holds PREADY=0 for 2 ACCESS cycles, PRDATA=0x12345678 -> PENABLE high 3 cycles, s_rdata=0x12345678, PSTRB=0, s_err=0.
- Two back-to-back writes to slaves 0 and 2, transfer held high -> second SETUP immediately follows first ACCESS; PSEL 0001->0100 with no idle cycle; two s_done pulses 2 cycles apart.
- SADDR=0x0000_5000 (idx 5) -> no PSEL ever asserted; s_done=1, s_err=1, s_rdata=0 next cycle.
- Slave 0 never asserts PREADY, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then s_done=1, s_err=1, PSEL/PENABLE=0.
- PRESET asserted during ACCESS -> PSEL/PENABLE 0 without a clock edge, no s_done; fresh read after release completes normally.

Source files
------------

// File: rtl/apb4_multi_slave_master.sv
// APB4 master bridge: turns a valid/ready request into SETUP/ACCESS phases,
// decodes the address to one of NUM_SLAVES selects and returns the selected response.
module apb4_multi_slave_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVES     = 4,
   parameter int SEL_LSB        = 12,
   parameter int SEL_BITS       = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             PCLK,
   input  logic                             PRESET,
   input  logic                             transfer,
   input  logic                             SWRITE,
   input  logic [ADDR_WIDTH-1:0]            SADDR,
   input  logic [DATA_WIDTH-1:0]            SWDATA,
   input  logic [DATA_WIDTH/8-1:0]          SSTRB,
   input  logic [2:0]                       SPROT,
   output logic                             s_ready,
   output logic                             s_done,
   output logic [DATA_WIDTH-1:0]            s_rdata,
   output logic                             s_err,
   output logic [NUM_SLAVES-1:0]            PSEL,
   output logic                             PENABLE,
   output logic                             PWRITE,
   output logic [ADDR_WIDTH-1:0]            PADDR,
   output logic [DATA_WIDTH-1:0]            PWDATA,
   output logic [DATA_WIDTH/8-1:0]          PSTRB,
   output logic [2:0]                       PPROT,
   input  logic [NUM_SLAVES-1:0]            PREADY,
   input  logic [NUM_SLAVES-1:0]            PSLVERR,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA
);

   localparam int TCNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t                  state, state_next;
   logic [SEL_BITS-1:0]     req_idx;
   logic [NUM_SLAVES-1:0]   req_sel;
   logic                    req_valid;
   logic                    accept;
   logic                    sel_ready;
   logic                    sel_err;
   logic [DATA_WIDTH-1:0]   sel_rdata;
   logic                    expiring;
   logic                    complete;
   logic                    err_pend;
   logic [TCNT_WIDTH-1:0]   tmo_cnt;

   assign req_idx = SADDR[SEL_LSB +: SEL_BITS];

   // An out-of-range index leaves req_sel all-zero, which doubles as the decode-error flag.
   always_comb begin
      req_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (req_idx == SEL_BITS'(i)) req_sel[i] = 1'b1;
   end
   assign req_valid = |req_sel;

   // PSEL is one-hot, so masking with it observes only the addressed slave.
   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (PSEL[i]) sel_rdata = sel_rdata | PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
   end
   assign sel_ready = |(PREADY & PSEL);
   assign sel_err   = |(PSLVERR & PSEL);

   assign expiring = (TIMEOUT_CYCLES != 0) && (state == ACCESS) && !sel_ready &&
                     (tmo_cnt == TCNT_WIDTH'(TIMEOUT_CYCLES - 1));
   assign complete = (state == ACCESS) && (sel_ready || expiring);

   // A decode error accepted while another transfer completes owes its s_done one cycle
   // later; requests are held off in IDLE until that pulse has gone out.
   assign s_ready = ((state == IDLE) && !err_pend) || complete;
   assign accept  = transfer && s_ready;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && req_valid) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS:  if (complete) state_next = (accept && req_valid) ? SETUP : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: every register sits in the async-reset branch and is updated with <=, so all
   // of them sample the same pre-edge values and a reset clears the bus without a clock.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         PSEL     <= '0;
         PENABLE  <= 1'b0;
         PWRITE   <= 1'b0;
         PADDR    <= '0;
         PWDATA   <= '0;
         PSTRB    <= '0;
         PPROT    <= '0;
         s_done   <= 1'b0;
         s_rdata  <= '0;
         s_err    <= 1'b0;
         err_pend <= 1'b0;
         tmo_cnt  <= '0;
      end else begin
         s_done <= 1'b0;
         if (err_pend) begin
            s_done   <= 1'b1;
            s_err    <= 1'b1;
            s_rdata  <= '0;
            err_pend <= 1'b0;
         end
         if (state == SETUP) PENABLE <= 1'b1;
         if (state == ACCESS && !sel_ready) tmo_cnt <= tmo_cnt + TCNT_WIDTH'(1);
         if (complete) begin
            s_done  <= 1'b1;
            s_err   <= expiring || sel_err;
            s_rdata <= (expiring || PWRITE) ? '0 : sel_rdata;
            PSEL    <= '0;
            PENABLE <= 1'b0;
         end
         if (accept) begin
            tmo_cnt <= '0;
            if (req_valid) begin
               PSEL    <= req_sel;
               PENABLE <= 1'b0;
               PWRITE  <= SWRITE;
               PADDR   <= SADDR;
               PWDATA  <= SWDATA;
               PSTRB   <= SWRITE ? SSTRB : '0;
               PPROT   <= SPROT;
            end else if (complete) begin
               err_pend <= 1'b1;
            end else begin
               s_done  <= 1'b1;
               s_err   <= 1'b1;
               s_rdata <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_apb4_multi_slave_master.sv
// Directed bench for apb4_multi_slave_master: a per-cycle vector table for the
// basic transfers, then hand sequences for timeout and mid-transfer reset.
module tb_apb4_multi_slave_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 4;
   localparam int NV = 19;

   logic            PCLK = 1'b0;
   logic            PRESET;
   logic            transfer;
   logic            SWRITE;
   logic [AW-1:0]   SADDR;
   logic [DW-1:0]   SWDATA;
   logic [DW/8-1:0] SSTRB;
   logic [2:0]      SPROT;
   logic            s_ready;
   logic            s_done;
   logic [DW-1:0]   s_rdata;
   logic            s_err;
   logic [NS-1:0]   PSEL;
   logic            PENABLE;
   logic            PWRITE;
   logic [AW-1:0]   PADDR;
   logic [DW-1:0]   PWDATA;
   logic [DW/8-1:0] PSTRB;
   logic [2:0]      PPROT;
   logic [NS-1:0]   PREADY;
   logic [NS-1:0]   PSLVERR;
   logic [NS*DW-1:0] PRDATA;

   apb4_multi_slave_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
      .SEL_LSB(12), .SEL_BITS(3), .TIMEOUT_CYCLES(16)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .SWRITE(SWRITE),
      .SADDR(SADDR), .SWDATA(SWDATA), .SSTRB(SSTRB), .SPROT(SPROT),
      .s_ready(s_ready), .s_done(s_done), .s_rdata(s_rdata), .s_err(s_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic          trn;
      logic          wr;
      logic [31:0]   addr;
      logic [31:0]   wdata;
      logic [3:0]    strb;
      logic [3:0]    rdy;
      logic [3:0]    slverr;
      logic          e_ready;
      logic [3:0]    e_psel;
      logic          e_pen;
      logic          e_pwr;
      logic [31:0]   e_paddr;
      logic [31:0]   e_pwdata;
      logic [3:0]    e_pstrb;
      logic          e_done;
      logic          e_err;
      logic [31:0]   e_rdata;
   } vec_t;

   vec_t vecs [NV];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic trn, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
      input logic [3:0] strb, input logic [3:0] rdy, input logic [3:0] slverr,
      input logic e_ready, input logic [3:0] e_psel, input logic e_pen, input logic e_pwr,
      input logic [31:0] e_paddr, input logic [31:0] e_pwdata, input logic [3:0] e_pstrb,
      input logic e_done, input logic e_err, input logic [31:0] e_rdata);
      vec_t v;
      v.trn = trn; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
      v.rdy = rdy; v.slverr = slverr; v.e_ready = e_ready; v.e_psel = e_psel;
      v.e_pen = e_pen; v.e_pwr = e_pwr; v.e_paddr = e_paddr; v.e_pwdata = e_pwdata;
      v.e_pstrb = e_pstrb; v.e_done = e_done; v.e_err = e_err; v.e_rdata = e_rdata;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit done_seen;
      int acc_cycles;

      // Write to slave 1, ready immediately.
      vecs[0]  = mk(1'b1, 1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 4'b0010, 4'b0000,
                    1'b1, 4'b0010, 1'b0, 1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0);
      vecs[1]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0010, 4'b0000,
                    1'b0, 4'b0010, 1'b1, 1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0);
      vecs[2]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0010, 4'b0000,
                    1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      vecs[3]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0000, 4'b0000,
                    1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      // Read from slave 3 with two wait states; other slaves' PREADY must be ignored.
      vecs[4]  = mk(1'b1, 1'b0, 32'h3010, 32'h55555555, 4'hF, 4'b0000, 4'b0000,
                    1'b1, 4'b1000, 1'b0, 1'b0, 32'h3010, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      vecs[5]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0111, 4'b0000,
                    1'b0, 4'b1000, 1'b1, 1'b0, 32'h3010, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      vecs[6]  = vecs[5];
      vecs[7]  = vecs[5];
      vecs[8]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b1000, 4'b0000,
                    1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h12345678);
      // Back-to-back writes to slaves 0 and 2 with transfer held high.
      vecs[9]  = mk(1'b1, 1'b1, 32'h0000, 32'h11111111, 4'h3, 4'b0101, 4'b0000,
                    1'b1, 4'b0001, 1'b0, 1'b1, 32'h0000, 32'h11111111, 4'h3, 1'b0, 1'b0, 32'h0);
      vecs[10] = mk(1'b1, 1'b1, 32'h2000, 32'h22222222, 4'hC, 4'b0101, 4'b0000,
                    1'b0, 4'b0001, 1'b1, 1'b1, 32'h0000, 32'h11111111, 4'h3, 1'b0, 1'b0, 32'h0);
      vecs[11] = mk(1'b1, 1'b1, 32'h2000, 32'h22222222, 4'hC, 4'b0101, 4'b0000,
                    1'b1, 4'b0100, 1'b0, 1'b1, 32'h2000, 32'h22222222, 4'hC, 1'b1, 1'b0, 32'h0);
      vecs[12] = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0101, 4'b0000,
                    1'b0, 4'b0100, 1'b1, 1'b1, 32'h2000, 32'h22222222, 4'hC, 1'b0, 1'b0, 32'h0);
      vecs[13] = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0101, 4'b0000,
                    1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      // Out-of-range index 5: decode error, no PSEL.
      vecs[14] = mk(1'b1, 1'b0, 32'h5000, 32'h0, 4'hF, 4'b1111, 4'b0000,
                    1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0);
      vecs[15] = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0000, 4'b0000,
                    1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      // Read from slave 2 returning PSLVERR.
      vecs[16] = mk(1'b1, 1'b0, 32'h2008, 32'h0, 4'hF, 4'b0100, 4'b0100,
                    1'b1, 4'b0100, 1'b0, 1'b0, 32'h2008, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      vecs[17] = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0100, 4'b0100,
                    1'b0, 4'b0100, 1'b1, 1'b0, 32'h2008, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      vecs[18] = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'b0100, 4'b0100,
                    1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'hCAFE0002);

      PRESET   = 1'b1;
      transfer = 1'b0;
      SWRITE   = 1'b0;
      SADDR    = '0;
      SWDATA   = '0;
      SSTRB    = '0;
      SPROT    = 3'b010;
      PREADY   = '0;
      PSLVERR  = '0;
      PRDATA   = {32'h12345678, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

      #2;
      check("reset_psel_pen", 64'({PSEL, PENABLE, PWRITE}), 64'h0);
      check("reset_paddr_pwdata", 64'({PADDR, PWDATA}), 64'h0);
      check("reset_pstrb_pprot", 64'({PSTRB, PPROT}), 64'h0);
      check("reset_sdone_err_rdata", 64'({s_done, s_err, s_rdata}), 64'h0);
      #10;
      PRESET = 1'b0;
      @(posedge PCLK); #1;

      for (int i = 0; i < NV; i++) begin
         transfer = vecs[i].trn;
         SWRITE   = vecs[i].wr;
         SADDR    = vecs[i].addr;
         SWDATA   = vecs[i].wdata;
         SSTRB    = vecs[i].strb;
         PREADY   = vecs[i].rdy;
         PSLVERR  = vecs[i].slverr;
         #1;
         check($sformatf("v%0d_s_ready", i), 64'(s_ready), 64'(vecs[i].e_ready));
         @(posedge PCLK); #1;
         check($sformatf("v%0d_psel", i), 64'(PSEL), 64'(vecs[i].e_psel));
         check($sformatf("v%0d_penable", i), 64'(PENABLE), 64'(vecs[i].e_pen));
         check($sformatf("v%0d_s_done", i), 64'(s_done), 64'(vecs[i].e_done));
         if (vecs[i].e_done) begin
            check($sformatf("v%0d_s_err", i), 64'(s_err), 64'(vecs[i].e_err));
            check($sformatf("v%0d_s_rdata", i), 64'(s_rdata), 64'(vecs[i].e_rdata));
         end
         if (vecs[i].e_psel != 4'b0000) begin
            check($sformatf("v%0d_paddr", i), 64'(PADDR), 64'(vecs[i].e_paddr));
            check($sformatf("v%0d_pstrb", i), 64'(PSTRB), 64'(vecs[i].e_pstrb));
            check($sformatf("v%0d_pwrite", i), 64'(PWRITE), 64'(vecs[i].e_pwr));
            check($sformatf("v%0d_pprot", i), 64'(PPROT), 64'(3'b010));
            if (vecs[i].e_pwr)
               check($sformatf("v%0d_pwdata", i), 64'(PWDATA), 64'(vecs[i].e_pwdata));
         end
      end

      // Timeout: slave 0 never ready.
      transfer = 1'b1; SWRITE = 1'b0; SADDR = 32'h0000_0040; PREADY = '0; PSLVERR = '0;
      @(posedge PCLK); #1;
      transfer = 1'b0;
      check("tmo_setup_psel", 64'(PSEL), 64'(4'b0001));
      done_seen  = 1'b0;
      acc_cycles = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge PCLK); #1;
         if (s_done) begin
            done_seen = 1'b1;
            break;
         end
         if (PENABLE) acc_cycles++;
      end
      check("tmo_done_seen", 64'(done_seen), 64'(1'b1));
      check("tmo_access_cycles", 64'(acc_cycles), 64'(16));
      check("tmo_s_err", 64'(s_err), 64'(1'b1));
      check("tmo_s_rdata", 64'(s_rdata), 64'h0);
      check("tmo_bus_released", 64'({PSEL, PENABLE}), 64'h0);

      // Reset during ACCESS, then a fresh read.
      @(posedge PCLK); #1;
      transfer = 1'b1; SWRITE = 1'b0; SADDR = 32'h0000_1000; PREADY = '0;
      @(posedge PCLK); #1;
      transfer = 1'b0;
      @(posedge PCLK); #1;
      check("rst_in_access_pen", 64'(PENABLE), 64'(1'b1));
      #2;
      PRESET = 1'b1;
      #1;
      check("rst_async_psel_pen", 64'({PSEL, PENABLE}), 64'h0);
      check("rst_async_s_done", 64'(s_done), 64'h0);
      PREADY = 4'b0010;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      done_seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge PCLK); #1;
         if (s_done) done_seen = 1'b1;
      end
      check("rst_no_done", 64'(done_seen), 64'(1'b0));
      transfer = 1'b1; SWRITE = 1'b0; SADDR = 32'h0000_1004;
      @(posedge PCLK); #1;
      transfer = 1'b0;
      check("post_rst_setup_psel", 64'({PSEL, PENABLE}), 64'({4'b0010, 1'b0}));
      @(posedge PCLK); #1;
      @(posedge PCLK); #1;
      check("post_rst_done", 64'(s_done), 64'(1'b1));
      check("post_rst_err", 64'(s_err), 64'(1'b0));
      check("post_rst_rdata", 64'(s_rdata), 64'(32'hCAFE0001));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
